spi_packet_slave: RTL and testbench

SPI_PACKET_SLAVE -- requirements
Module: spi_packet_slave

---
 rtl/spi_packet_slave.sv | 184 ++++++++++++++++++
 tb/tb_spi_packet_slave.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_packet_slave.sv
// SPI slave that exchanges fixed-size packets between an SPI bus, a TX shadow register and an RX FIFO.
// Defining SPI_PACKET_SLAVE_LOOPBACK_EN echoes every accepted RX packet back out on the next transfer.
module spi_packet_slave #(
    parameter int BYTE_SIZE   = 8,
    parameter int PACKET_SIZE = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int FIFO_DEPTH  = 4,
    localparam int W  = BYTE_SIZE * PACKET_SIZE,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clkIn,
    input  logic          nResetIn,
    input  logic          ssIn,
    input  logic          sckIn,
    input  logic          mosiIn,
    output logic          misoOut,
    input  logic [W-1:0]  txDataIn,
    input  logic          txValidIn,
    output logic          txReadyOut,
    output logic [W-1:0]  rxDataOut,
    output logic          rxValidOut,
    input  logic          rxReadyIn,
    output logic [CW-1:0] fifoCountOut,
    output logic          overrunOut,
    output logic          busyOut
);
    localparam int   PW          = $clog2(FIFO_DEPTH);
    localparam int   BW          = $clog2(W + 1);
    localparam logic SCK_IDLE    = (CPOL != 0);
    localparam logic LATE_SAMPLE = (CPHA != 0);
`ifdef SPI_PACKET_SLAVE_LOOPBACK_EN
    localparam logic LOOPBACK = 1'b1;
`else
    localparam logic LOOPBACK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    logic [2:0]    sync1_q, sync2_q, histA_q, histB_q, histC_q, filt;
    logic          ssPrev_q, sckPrev_q;
    logic          ssFilt, sckFilt, mosiFilt, ssFall, ssRise;
    logic          sckEdge, leadEdge, trailEdge, sampleEdge, shiftEdge;
    state_t        state_q;
    logic [BW-1:0] bitCnt_q;
    logic [W-1:0]  txShift_q, rxShift_q, shadow_q, loadData;
    logic          shadowFull_q, miso_q, txFire;
    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0] wrPtr_q, rdPtr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, push, pop, full, pushOk;

    // Pins {ss, sck, mosi}: two flops against metastability, then a 3-deep majority vote.
    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            histA_q   <= '0;
            histB_q   <= '0;
            histC_q   <= '0;
            ssPrev_q  <= 1'b0;
            sckPrev_q <= 1'b0;
        end else begin
            sync1_q   <= {ssIn, sckIn, mosiIn};
            sync2_q   <= sync1_q;
            histA_q   <= sync2_q;
            histB_q   <= histA_q;
            histC_q   <= histB_q;
            ssPrev_q  <= ssFilt;
            sckPrev_q <= sckFilt;
        end
    end

    assign filt       = (histA_q & histB_q) | (histA_q & histC_q) | (histB_q & histC_q);
    assign ssFilt     = filt[2];
    assign sckFilt    = filt[1];
    assign mosiFilt   = filt[0];
    assign ssFall     = ssPrev_q & ~ssFilt;
    assign ssRise     = ~ssPrev_q & ssFilt;
    assign sckEdge    = sckFilt ^ sckPrev_q;
    assign leadEdge   = sckEdge & (sckFilt != SCK_IDLE);
    assign trailEdge  = sckEdge & (sckFilt == SCK_IDLE);
    assign sampleEdge = LATE_SAMPLE ? trailEdge : leadEdge;
    assign shiftEdge  = LATE_SAMPLE ? leadEdge : trailEdge;

    assign rxValidOut = (count_q != '0);
    assign pop        = rxValidOut & rxReadyIn;
    assign push       = (state_q == DONE);
    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign pushOk     = push & (~full | pop);
    assign txReadyOut = ~LOOPBACK & ~shadowFull_q;
    assign txFire     = txValidIn & txReadyOut;
    assign loadData   = (LOOPBACK && pushOk) ? rxShift_q : (shadowFull_q ? shadow_q : '0);

    // With CPHA=0 the MSB must already be on MISO before the first sample edge, so it is
    // driven at load time and the trailing edge that closes the previous packet is skipped.
    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            state_q      <= IDLE;
            bitCnt_q     <= '0;
            txShift_q    <= '0;
            rxShift_q    <= '0;
            shadow_q     <= '0;
            shadowFull_q <= 1'b0;
            miso_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ssFall) begin
                        state_q      <= SHIFT;
                        bitCnt_q     <= '0;
                        txShift_q    <= LATE_SAMPLE ? loadData : (loadData << 1);
                        shadowFull_q <= 1'b0;
                        if (!LATE_SAMPLE) miso_q <= loadData[W-1];
                    end else begin
                        miso_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (ssRise) begin
                        state_q <= IDLE;
                    end else begin
                        if (sampleEdge) begin
                            rxShift_q <= {rxShift_q[W-2:0], mosiFilt};
                            if (bitCnt_q == BW'(W - 1)) state_q <= DONE;
                            else bitCnt_q <= bitCnt_q + BW'(1);
                        end
                        if (shiftEdge && (LATE_SAMPLE || bitCnt_q != '0)) begin
                            miso_q    <= txShift_q[W-1];
                            txShift_q <= txShift_q << 1;
                        end
                    end
                end
                DONE: begin
                    state_q      <= ssFilt ? IDLE : SHIFT;
                    bitCnt_q     <= '0;
                    txShift_q    <= LATE_SAMPLE ? loadData : (loadData << 1);
                    shadowFull_q <= 1'b0;
                    if (!LATE_SAMPLE) miso_q <= loadData[W-1];
                    if (LOOPBACK && pushOk) begin
                        shadow_q     <= rxShift_q;
                        shadowFull_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (txFire) begin
                shadow_q     <= txDataIn;
                shadowFull_q <= 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (pushOk && !pop) count_d = count_q + CW'(1);
        else if (!pushOk && pop) count_d = count_q - CW'(1);
    end

    // Power-of-two depth lets the pointers wrap on their own.
    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (pushOk) wrPtr_q <= wrPtr_q + PW'(1);
            if (pop) rdPtr_q <= rdPtr_q + PW'(1);
            count_q   <= count_d;
            overrun_q <= push & ~pushOk;
        end
    end

    always_ff @(posedge clkIn) begin
        if (pushOk) mem_q[wrPtr_q] <= rxShift_q;
    end

    assign rxDataOut    = rxValidOut ? mem_q[rdPtr_q] : '0;
    assign fifoCountOut = count_q;
    assign overrunOut   = overrun_q;
    assign busyOut      = (state_q != IDLE);
    assign misoOut      = miso_q & ~ssFilt;
endmodule

// File: tb/tb_spi_packet_slave.sv
// Bench for spi_packet_slave: four instances, one per CPOL/CPHA mode, driven by one bit-banged SPI master.
// MOSI changes mid-way through the SCK low phase so one waveform is valid for both sampling phases.
module tb_spi_packet_slave;
    logic        clkIn = 1'b0;
    logic        nResetIn = 1'b0;
    logic        ssIn = 1'b1;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic [63:0] txData = '0;
    logic        txValid = 1'b0;
    logic        rxReady = 1'b0;

    logic [3:0]  misoW, txReadyW, rxValidW, overrunW, busyW;
    logic [63:0] rxDataW [4];
    logic [2:0]  countW [4];
    logic [63:0] misoCap [4];
    int          ovrPulses [4];
    int          checks = 0;
    int          fails = 0;
    logic        expTxReady;

    always #5 clkIn = ~clkIn;

    for (genvar g = 0; g < 4; g++) begin : gDut
        spi_packet_slave #(.CPOL(g / 2), .CPHA(g % 2)) u_dut (
            .clkIn(clkIn),
            .nResetIn(nResetIn),
            .ssIn(ssIn),
            .sckIn((g >= 2) ? ~sck : sck),
            .mosiIn(mosi),
            .misoOut(misoW[g]),
            .txDataIn(txData),
            .txValidIn(txValid),
            .txReadyOut(txReadyW[g]),
            .rxDataOut(rxDataW[g]),
            .rxValidOut(rxValidW[g]),
            .rxReadyIn(rxReady),
            .fifoCountOut(countW[g]),
            .overrunOut(overrunW[g]),
            .busyOut(busyW[g])
        );
    end

    always @(posedge clkIn) begin
        for (int g = 0; g < 4; g++) if (overrunW[g]) ovrPulses[g]++;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clkIn);
        #1;
    endtask

    task automatic frameStart();
        ssIn = 1'b0;
        waitCycles(8);
    endtask

    task automatic frameEnd();
        waitCycles(4);
        ssIn = 1'b1;
        waitCycles(12);
    endtask

    task automatic popOne();
        rxReady = 1'b1;
        waitCycles(1);
        rxReady = 1'b0;
    endtask

    // Shifts the top nbits of data MSB first; leading-edge samplers are captured before each leading edge,
    // trailing-edge samplers before each trailing edge.
    task automatic shiftBits(input logic [63:0] data, input int nbits);
        for (int i = 63; i > 63 - nbits; i--) begin
            mosi = data[i];
            waitCycles(4);
            for (int g = 0; g < 4; g += 2) misoCap[g][i] = misoW[g];
            sck = 1'b1;
            waitCycles(8);
            for (int g = 1; g < 4; g += 2) misoCap[g][i] = misoW[g];
            sck = 1'b0;
            waitCycles(4);
        end
    endtask

    task automatic loadShadow(input logic [63:0] data);
        int k;
        k = 0;
        while (k < 20 && txReadyW[0] !== 1'b1) begin
            waitCycles(1);
            k++;
        end
        checks++;
        if (txReadyW[0] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL loadShadow_ready: txReadyOut=%b required 1 within 20 cycles", txReadyW[0]);
        end
        txData = data;
        txValid = 1'b1;
        waitCycles(1);
        txValid = 1'b0;
    endtask

    task automatic test_reset();
        nResetIn = 1'b0;
        #25;
        for (int g = 0; g < 4; g++) begin
            checks++;
            if ({misoW[g], rxValidW[g], txReadyW[g], overrunW[g], busyW[g], countW[g]} !==
                {1'b0, 1'b0, expTxReady, 1'b0, 1'b0, 3'd0}) begin
                fails++;
                $display("[TB] FAIL reset_status[%0d]: miso/rxv/txr/ovr/busy/cnt=%b required %b", g,
                         {misoW[g], rxValidW[g], txReadyW[g], overrunW[g], busyW[g], countW[g]},
                         {1'b0, 1'b0, expTxReady, 1'b0, 1'b0, 3'd0});
            end
            checks++;
            if (rxDataW[g] !== 64'd0) begin
                fails++;
                $display("[TB] FAIL reset_rxData[%0d]: got %h required 0", g, rxDataW[g]);
            end
        end
        nResetIn = 1'b1;
        waitCycles(20);
    endtask

    task automatic test_basic();
        loadShadow(64'h0123456789ABCDEF);
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (txReadyW[g] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL basic_txReadyFull[%0d]: got %b required 0", g, txReadyW[g]);
            end
        end
        frameStart();
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (busyW[g] !== 1'b1) begin
                fails++;
                $display("[TB] FAIL basic_busy[%0d]: got %b required 1", g, busyW[g]);
            end
        end
        shiftBits(64'hFEDCBA9876543210, 64);
        frameEnd();
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (misoCap[g] !== 64'h0123456789ABCDEF) begin
                fails++;
                $display("[TB] FAIL basic_miso[%0d]: got %h required 0123456789abcdef", g, misoCap[g]);
            end
            checks++;
            if (rxDataW[g] !== 64'hFEDCBA9876543210) begin
                fails++;
                $display("[TB] FAIL basic_rxData[%0d]: got %h required fedcba9876543210", g, rxDataW[g]);
            end
            checks++;
            if ({countW[g], rxValidW[g], txReadyW[g], busyW[g]} !== {3'd1, 1'b1, 1'b1, 1'b0}) begin
                fails++;
                $display("[TB] FAIL basic_status[%0d]: cnt/rxv/txr/busy=%b required 001110", g,
                         {countW[g], rxValidW[g], txReadyW[g], busyW[g]});
            end
        end
        popOne();
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (countW[g] !== 3'd0 || rxValidW[g] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL basic_pop[%0d]: count=%0d rxValid=%b required 0/0", g, countW[g], rxValidW[g]);
            end
        end
    endtask

    task automatic test_back_to_back();
        loadShadow(64'h13579BDF2468ACE0);
        frameStart();
        loadShadow(64'hC3C35A5A0F0F9669);
        txData = 64'hFFFF0000FFFF0000;
        txValid = 1'b1;
        waitCycles(2);
        txValid = 1'b0;
        shiftBits(64'h0011223344556677, 64);
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (misoCap[g] !== 64'h13579BDF2468ACE0) begin
                fails++;
                $display("[TB] FAIL b2b_miso1[%0d]: got %h required 13579bdf2468ace0", g, misoCap[g]);
            end
        end
        shiftBits(64'h8899AABBCCDDEEFF, 64);
        frameEnd();
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (misoCap[g] !== 64'hC3C35A5A0F0F9669) begin
                fails++;
                $display("[TB] FAIL b2b_miso2[%0d]: got %h required c3c35a5a0f0f9669", g, misoCap[g]);
            end
            checks++;
            if (countW[g] !== 3'd2 || rxDataW[g] !== 64'h0011223344556677) begin
                fails++;
                $display("[TB] FAIL b2b_head[%0d]: count=%0d data=%h required 2/0011223344556677", g, countW[g], rxDataW[g]);
            end
        end
        popOne();
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (rxDataW[g] !== 64'h8899AABBCCDDEEFF) begin
                fails++;
                $display("[TB] FAIL b2b_second[%0d]: got %h required 8899aabbccddeeff", g, rxDataW[g]);
            end
        end
        popOne();
    endtask

    task automatic test_overrun();
        for (int g = 0; g < 4; g++) ovrPulses[g] = 0;
        for (int k = 1; k <= 5; k++) begin
            frameStart();
            shiftBits(64'hA5A5000000000000 | 64'(k), 64);
            frameEnd();
        end
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (countW[g] !== 3'd4 || ovrPulses[g] !== 1) begin
                fails++;
                $display("[TB] FAIL overrun_full[%0d]: count=%0d pulses=%0d required 4/1", g, countW[g], ovrPulses[g]);
            end
        end
        for (int k = 1; k <= 4; k++) begin
            for (int g = 0; g < 4; g++) begin
                checks++;
                if (rxDataW[g] !== (64'hA5A5000000000000 | 64'(k))) begin
                    fails++;
                    $display("[TB] FAIL overrun_order[%0d] entry %0d: got %h required %h", g, k, rxDataW[g],
                             64'hA5A5000000000000 | 64'(k));
                end
            end
            popOne();
        end
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (countW[g] !== 3'd0) begin
                fails++;
                $display("[TB] FAIL overrun_drain[%0d]: count=%0d required 0", g, countW[g]);
            end
        end
    endtask

    task automatic test_partial();
        frameStart();
        shiftBits(64'h5555555555555555, 13);
        frameEnd();
        frameStart();
        shiftBits(64'hAAAAAAAAAAAAAAAA, 64);
        frameEnd();
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (countW[g] !== 3'd1 || rxDataW[g] !== 64'hAAAAAAAAAAAAAAAA) begin
                fails++;
                $display("[TB] FAIL partial[%0d]: count=%0d data=%h required 1/aaaaaaaaaaaaaaaa", g, countW[g], rxDataW[g]);
            end
        end
    endtask

    task automatic test_reset_mid();
        frameStart();
        loadShadow(64'hDEADBEEFCAFEF00D);
        shiftBits(64'h123456789ABCDEF0, 30);
        nResetIn = 1'b0;
        waitCycles(3);
        for (int g = 0; g < 4; g++) begin
            checks++;
            if ({misoW[g], rxValidW[g], txReadyW[g], overrunW[g], busyW[g], countW[g]} !==
                {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0} || rxDataW[g] !== 64'd0) begin
                fails++;
                $display("[TB] FAIL resetMid_status[%0d]: miso/rxv/txr/ovr/busy/cnt=%b data=%h required 00100000/0", g,
                         {misoW[g], rxValidW[g], txReadyW[g], overrunW[g], busyW[g], countW[g]}, rxDataW[g]);
            end
        end
        nResetIn = 1'b1;
        waitCycles(20);
        shiftBits(64'hFFFFFFFFFFFFFFFF, 8);
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (busyW[g] !== 1'b0 || countW[g] !== 3'd0) begin
                fails++;
                $display("[TB] FAIL resetMid_noFrame[%0d]: busy=%b count=%0d required 0/0", g, busyW[g], countW[g]);
            end
        end
        frameEnd();
        frameStart();
        shiftBits(64'h5A5A5A5A5A5A5A5A, 64);
        frameEnd();
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (countW[g] !== 3'd1 || rxDataW[g] !== 64'h5A5A5A5A5A5A5A5A || misoCap[g] !== 64'd0) begin
                fails++;
                $display("[TB] FAIL resetMid_next[%0d]: count=%0d data=%h miso=%h required 1/5a5a5a5a5a5a5a5a/0", g,
                         countW[g], rxDataW[g], misoCap[g]);
            end
        end
        popOne();
    endtask

    task automatic test_loopback();
        frameStart();
        shiftBits(64'h1111111111111111, 64);
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (misoCap[g] !== 64'd0 || txReadyW[g] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL loopback_first[%0d]: miso=%h txReady=%b required 0/0", g, misoCap[g], txReadyW[g]);
            end
        end
        shiftBits(64'h2222222222222222, 64);
        frameEnd();
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (misoCap[g] !== 64'h1111111111111111) begin
                fails++;
                $display("[TB] FAIL loopback_echo[%0d]: got %h required 1111111111111111", g, misoCap[g]);
            end
            checks++;
            if (txReadyW[g] !== 1'b0 || countW[g] !== 3'd2) begin
                fails++;
                $display("[TB] FAIL loopback_status[%0d]: txReady=%b count=%0d required 0/2", g, txReadyW[g], countW[g]);
            end
        end
        popOne();
        popOne();
    endtask

    initial begin
`ifdef SPI_PACKET_SLAVE_LOOPBACK_EN
        expTxReady = 1'b0;
        test_reset();
        test_loopback();
        test_overrun();
        test_partial();
`else
        expTxReady = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_partial();
        test_reset_mid();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
